// File: rtl/shift_add_mult_core.sv
// Sequential shift-add multiplier: WIDTH iterations, registered 2*WIDTH-bit product, start/busy/done handshake.
// Define MULT_SIGNED_EN to build two's-complement support (magnitude conversion plus result negation).
module shift_add_mult_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t               r_state, w_state_next;
    logic                 r_busy, r_done, w_busy_next, w_done_next;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_sgn;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_full;

`ifdef MULT_SIGNED_EN
    assign w_sgn   = signed_mode;
    // Magnitudes stay unsigned WIDTH bits so |-2^(WIDTH-1)| is representable.
    assign w_mag_a = (w_sgn && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign w_mag_b = (w_sgn && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
`else
    logic w_unused;
    assign w_unused = signed_mode;
    assign w_sgn    = 1'b0;
    assign w_mag_a  = multiplicand;
    assign w_mag_b  = multiplier;
`endif

    // Adder is one bit wider than the operand so the carry survives the shift.
    assign w_sum      = r_acc + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_full = {r_acc[WIDTH-1:0], r_mplier};

    always_comb begin
        w_state_next = r_state;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        if (clr) begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    w_state_next = S_RUN;
                    w_busy_next  = 1'b1;
                end
                S_RUN: if (r_cnt == LAST) w_state_next = S_FIN;
                S_FIN: begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (clr) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_mcand  <= w_mag_a;
                    r_mplier <= w_mag_b;
                    r_neg    <= w_sgn & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                S_RUN: begin
                    {r_acc, r_mplier} <= {w_sum, r_mplier} >> 1;
                    r_cnt             <= r_cnt + CW'(1);
                end
                S_FIN: r_product <= r_neg ? -w_acc_full : w_acc_full;
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
